// File: rtl/axi_stream_to_data_pkg.sv
// axi_stream_to_data_pkg: shared helpers for the stream receive path
package axi_stream_to_data_pkg;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_sr.sv
// sync_fifo_sr: show-ahead synchronous fifo with sync active-high reset
module sync_fifo_sr
  import axi_stream_to_data_pkg::*;
#(
  parameter int W = 1025,
  parameter int DEPTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [W-1:0]              wr_data,
  input  logic                      rd_en,
  output logic [W-1:0]              rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [lvl_w(DEPTH)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push, pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= wr_data;
endmodule

// File: rtl/axi_stream_to_data.sv
// axi_stream_to_data: axi-stream slave buffering beats to a show-ahead port with packet length checking
module axi_stream_to_data
  import axi_stream_to_data_pkg::*;
#(
  parameter int DATA_WIDTH = 1024,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            S_AXIS_tvalid,
  output logic                            S_AXIS_tready,
  input  logic [DATA_WIDTH-1:0]           S_AXIS_tdata,
  input  logic                            S_AXIS_tlast,
  output logic                            data_valid,
  input  logic                            data_ready,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            data_last,
  input  logic [31:0]                     expected_len,
  input  logic                            clear_errors,
  output logic [31:0]                     beat_count,
  output logic [31:0]                     packet_count,
  output logic                            length_error,
  output logic [lvl_w(FIFO_DEPTH)-1:0]    fifo_level
);
  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;
  entry_t wr_e, rd_e;
  logic full, empty, acc, mism;
  logic [31:0] n;
  assign wr_e = '{last: S_AXIS_tlast, data: S_AXIS_tdata};
  assign {data_last, data_out} = rd_e;
  assign S_AXIS_tready = !full && !rst;
  assign data_valid = !empty;
  assign acc = S_AXIS_tvalid && S_AXIS_tready;
  assign n = beat_count + 32'd1;
  assign mism = acc && expected_len != '0 && (S_AXIS_tlast ? n != expected_len : n == expected_len);
  sync_fifo_sr #(.W(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(acc),
    .wr_data(wr_e),
    .rd_en(data_ready),
    .rd_data(rd_e),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count <= '0;
      packet_count <= '0;
      length_error <= 1'b0;
    end else begin
      if (acc) begin
        beat_count <= S_AXIS_tlast ? '0 : n;
        packet_count <= packet_count + 32'(S_AXIS_tlast);
      end
      length_error <= mism || (length_error && !clear_errors);
    end
  end
endmodule

// File: tb/tb_axi_stream_to_data.sv
// tb_axi_stream_to_data: randomized and directed check of the stream receiver against a queue model
module tb_axi_stream_to_data;
  localparam int DW = 1024;
  localparam int DEPTH = 32;
  typedef struct {
    logic          last;
    logic [DW-1:0] data;
  } ent_t;
  logic clk = 0, rst = 0;
  logic S_AXIS_tvalid = 0, S_AXIS_tready, S_AXIS_tlast = 0;
  logic [DW-1:0] S_AXIS_tdata = '0, data_out;
  logic data_valid, data_ready = 0, data_last, length_error, clear_errors = 0;
  logic [31:0] expected_len = 0, beat_count, packet_count;
  logic [5:0] fifo_level;
  ent_t q[$];
  int vectors = 0, errors = 0, n_acc = 0;
  logic [31:0] mb = 0, mp = 0;
  logic merr = 0;
  axi_stream_to_data #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .S_AXIS_tvalid(S_AXIS_tvalid),
    .S_AXIS_tready(S_AXIS_tready),
    .S_AXIS_tdata(S_AXIS_tdata),
    .S_AXIS_tlast(S_AXIS_tlast),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .data_out(data_out),
    .data_last(data_last),
    .expected_len(expected_len),
    .clear_errors(clear_errors),
    .beat_count(beat_count),
    .packet_count(packet_count),
    .length_error(length_error),
    .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32+:32] = $urandom;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[127:0], exp[127:0]);
    end
  endtask
  task automatic cyc();
    logic acc, pop;
    logic [31:0] n;
    @(negedge clk);
    chk("tready", S_AXIS_tready, q.size() != DEPTH);
    chk("data_valid", data_valid, q.size() != 0);
    chk("fifo_level", fifo_level, q.size());
    chk("beat_count", beat_count, mb);
    chk("packet_count", packet_count, mp);
    chk("length_error", length_error, merr);
    acc = S_AXIS_tvalid && q.size() != DEPTH;
    pop = data_ready && q.size() != 0;
    if (pop) begin
      chk("data_out", data_out, q[0].data);
      chk("data_last", data_last, q[0].last);
    end
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (clear_errors) merr = 0;
    if (acc) begin
      n = mb + 1;
      if (expected_len != 0 && (S_AXIS_tlast ? n != expected_len : n == expected_len)) merr = 1;
      q.push_back('{last: S_AXIS_tlast, data: S_AXIS_tdata});
      mb = S_AXIS_tlast ? 0 : n;
      if (S_AXIS_tlast) mp++;
      n_acc++;
    end
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    S_AXIS_tvalid = 0;
    data_ready = 0;
    clear_errors = 0;
    @(negedge clk);
    chk("tready_in_rst", S_AXIS_tready, 1'b0);
    @(posedge clk);
    #1 rst = 0;
    q.delete();
    mb = 0;
    mp = 0;
    merr = 0;
  endtask
  task automatic send(input int len, input int last_at);
    S_AXIS_tvalid = 1;
    for (int i = 1; i <= len; i++) begin
      S_AXIS_tdata = rnd();
      S_AXIS_tlast = (i == last_at);
      cyc();
    end
    S_AXIS_tvalid = 0;
    S_AXIS_tlast = 0;
  endtask
  initial begin
    int k, sent;
    do_reset();
    chk("rst_data_out", data_out, '0);
    chk("rst_data_last", data_last, 1'b0);
    cyc();
    expected_len = 4;
    data_ready = 1;
    S_AXIS_tvalid = 1;
    for (int i = 0; i < 4; i++) begin
      S_AXIS_tdata = DW'(10 + i);
      S_AXIS_tlast = (i == 3);
      cyc();
    end
    S_AXIS_tvalid = 0;
    S_AXIS_tlast = 0;
    repeat (3) cyc();
    chk("pkt1_count", packet_count, 32'd1);
    chk("pkt1_err", length_error, 1'b0);
    expected_len = 0;
    data_ready = 0;
    k = n_acc;
    S_AXIS_tvalid = 1;
    for (int i = 0; i < 34; i++) begin
      S_AXIS_tdata = rnd();
      cyc();
    end
    chk("fill_accepted", n_acc - k, 32);
    chk("fill_level", fifo_level, 6'd32);
    chk("fill_tready", S_AXIS_tready, 1'b0);
    data_ready = 1;
    cyc();
    data_ready = 0;
    for (int i = 0; i < 3; i++) begin
      S_AXIS_tdata = rnd();
      cyc();
    end
    chk("refill_accepted", n_acc - k, 33);
    do_reset();
    expected_len = 4;
    data_ready = 1;
    send(3, 3);
    chk("short_err", length_error, 1'b1);
    clear_errors = 1;
    cyc();
    clear_errors = 0;
    cyc();
    chk("cleared_err", length_error, 1'b0);
    send(3, 0);
    chk("no_err_yet", length_error, 1'b0);
    send(1, 0);
    chk("missing_last_err", length_error, 1'b1);
    send(1, 1);
    repeat (3) cyc();
    expected_len = 3;
    sent = 0;
    S_AXIS_tdata = rnd();
    S_AXIS_tlast = ($urandom % 5 == 0);
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      S_AXIS_tvalid = ($urandom % 4 != 0);
      data_ready = ($urandom % 3 != 0);
      clear_errors = ($urandom % 16 == 0);
      k = n_acc;
      cyc();
      if (n_acc != k) begin
        sent++;
        S_AXIS_tdata = rnd();
        S_AXIS_tlast = ($urandom % 5 == 0);
      end
    end
    chk("rand_sent", sent, 1000);
    S_AXIS_tvalid = 0;
    S_AXIS_tlast = 0;
    clear_errors = 0;
    data_ready = 1;
    repeat (40) cyc();
    chk("rand_drained", fifo_level, 6'd0);
    data_ready = 0;
    expected_len = 0;
    send(10, 0);
    chk("mid_level", fifo_level, 6'd10);
    do_reset();
    cyc();
    chk("mid_rst_valid", data_valid, 1'b0);
    chk("mid_rst_level", fifo_level, 6'd0);
    chk("mid_rst_beats", beat_count, 32'd0);
    data_ready = 1;
    send(2, 2);
    cyc();
    chk("mid_rst_pkts", packet_count, 32'd1);
    do_reset();
    data_ready = 1;
    send(1, 1);
    send(7, 7);
    send(2, 2);
    repeat (4) cyc();
    chk("nochk_err", length_error, 1'b0);
    chk("nochk_pkts", packet_count, 32'd3);
    chk("nochk_beats", beat_count, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
